// File: rtl/f_fetch_pkg.sv
// Shared constants and types for the fetch stage.
// Optional address-fault check is enabled by defining F_EXC_EN.
package f_fetch_pkg;

  localparam logic [31:0] F_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] F_NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL    = 5'd4;

  // Legal instruction fetch window used by the optional fault check
  localparam logic [31:0] F_TEXT_LO   = 32'h0000_3000;
  localparam logic [31:0] F_TEXT_HI   = 32'h0000_6FFF;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } f_state_e;

endpackage

// File: rtl/f_fetch_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface f_fetch_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ack;

  modport master (output im_req, output im_addr, input im_rdata, input im_ack);
  modport slave  (input im_req, input im_addr, output im_rdata, output im_ack);
endinterface

// File: rtl/f_d_reg.sv
// F/D pipeline register: load-enabled, resets to a NOP bubble.
// D_ExcCode path present only when F_EXC_EN is defined.
module f_d_reg
  import f_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = F_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
`ifdef F_EXC_EN
  input  logic [4:0]  exc_i,
  output logic [4:0]  exc_o,
`endif
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
`ifdef F_EXC_EN
  logic [4:0]  exc_q, exc_d;
`endif

  // Capture new contents on load, otherwise hold
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
`ifdef F_EXC_EN
    exc_d   = exc_q;
`endif
    if (load) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
`ifdef F_EXC_EN
      exc_d   = exc_i;
`endif
    end
  end

  // Register with synchronous reset to a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
`ifdef F_EXC_EN
      exc_q   <= '0;
`endif
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
`ifdef F_EXC_EN
      exc_q   <= exc_d;
`endif
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
`ifdef F_EXC_EN
  assign exc_o   = exc_q;
`endif

endmodule

// File: rtl/f_fetch.sv
// Fetch stage: PC register, req/ack instruction fetch FSM, F/D register.
// Defining F_EXC_EN adds the misaligned/out-of-range fetch fault (AdEL)
// and the D_ExcCode output.
module f_fetch
  import f_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = F_RESET_PC,
  parameter logic [31:0] NOP_INSTR = F_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Npc,
  input  logic        stall,
  output logic [31:0] F_PC,
  f_fetch_if.master   im,
  output logic        F_wait,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
`ifdef F_EXC_EN
  output logic [4:0]  D_ExcCode,
`endif
  output logic        D_valid
);

  f_state_e    state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        fault;
  logic        d_load;
  logic [31:0] d_instr;
`ifdef F_EXC_EN
  logic [4:0]  d_exc;
`endif

  // Address fault detection on the current fetch PC
  always_comb begin
`ifdef F_EXC_EN
    fault = (pc_q[1:0] != 2'b00) || (pc_q < F_TEXT_LO) || (pc_q > F_TEXT_HI);
`else
    fault = 1'b0;
`endif
  end

  // State, PC and word buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Next state: advance PC and load F/D only when a word (or fault) retires unstalled
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    d_load  = 1'b0;
    d_instr = im.im_rdata;
`ifdef F_EXC_EN
    d_exc   = '0;
`endif
    unique case (state_q)
      ST_REQ: begin
        if (fault) begin
          if (!stall) begin
            d_load  = 1'b1;
            d_instr = NOP_INSTR;
            pc_d    = Npc;
`ifdef F_EXC_EN
            d_exc   = EXC_ADEL;
`endif
          end
        end else if (im.im_ack) begin
          if (!stall) begin
            d_load = 1'b1;
            pc_d   = Npc;
          end else begin
            // Park the word so the ack is not lost while D is frozen
            buf_d   = im.im_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          d_load  = 1'b1;
          d_instr = buf_q;
          pc_d    = Npc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Handshake outputs; request suppressed during the reset cycle and on fault
  always_comb begin
    im.im_req = 1'b0;
    F_wait    = 1'b0;
    if (!reset && state_q == ST_REQ && !fault) begin
      im.im_req = 1'b1;
      F_wait    = ~im.im_ack;
    end
  end

  assign im.im_addr = pc_q;
  assign F_PC       = pc_q;

  f_d_reg #(.NOP_INSTR(NOP_INSTR)) u_f_d_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (d_load),
    .instr_i (d_instr),
    .pc_i    (pc_q),
`ifdef F_EXC_EN
    .exc_i   (d_exc),
    .exc_o   (D_ExcCode),
`endif
    .instr_o (D_Instr),
    .pc_o    (D_PC),
    .valid_o (D_valid)
  );

endmodule

// File: tb/tb_f_fetch.sv
// Directed self-checking bench for f_fetch.
module tb_f_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] npc;
  logic [31:0] f_pc;
  logic        f_wait;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
`ifdef F_EXC_EN
  logic [4:0]  d_exc;
`endif

  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        npc_override = 1'b0;
  logic [31:0] man_npc = '0;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  f_fetch_if bus ();

  always #5 clk = ~clk;

  // Zero-wait memory returns {16'hA5A5, addr[15:0]}; otherwise manual ack
  assign bus.im_ack   = auto_ack ? bus.im_req : man_ack;
  assign bus.im_rdata = auto_ack ? {16'hA5A5, bus.im_addr[15:0]} : man_rdata;
  assign npc          = npc_override ? man_npc : f_pc + 32'd4;

  f_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .Npc       (npc),
    .stall     (stall),
    .F_PC      (f_pc),
    .im        (bus.master),
    .F_wait    (f_wait),
    .D_Instr   (d_instr),
    .D_PC      (d_pc),
`ifdef F_EXC_EN
    .D_ExcCode (d_exc),
`endif
    .D_valid   (d_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    auto_ack = 1'b0; man_ack = 1'b0; stall = 1'b0;
    reset = 1'b1;
    tick(); tick();
    total_cnt++; if (f_pc !== 32'h3000) $display("FAIL rst_fpc got %h want %h", f_pc, 32'h3000); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b0) $display("FAIL rst_dvalid got %b want 0", d_valid); else pass_cnt++;
    total_cnt++; if (d_instr !== 32'h0) $display("FAIL rst_dinstr got %h want 0", d_instr); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h0) $display("FAIL rst_dpc got %h want 0", d_pc); else pass_cnt++;
    total_cnt++; if (bus.im_req !== 1'b0) $display("FAIL rst_imreq got %b want 0", bus.im_req); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (bus.im_req !== 1'b1) $display("FAIL rst_imreq_rise got %b want 1", bus.im_req); else pass_cnt++;
    total_cnt++; if (f_wait !== 1'b1) $display("FAIL rst_fwait got %b want 1", f_wait); else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    auto_ack = 1'b1;
    #1;
    exp_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (f_wait !== 1'b0) $display("FAIL zw_fwait[%0d] got %b want 0", i, f_wait); else pass_cnt++;
      tick();
      total_cnt++; if (d_pc !== exp_pc) $display("FAIL zw_dpc[%0d] got %h want %h", i, d_pc, exp_pc); else pass_cnt++;
      total_cnt++; if (d_instr !== {16'hA5A5, exp_pc[15:0]}) $display("FAIL zw_dinstr[%0d] got %h want %h", i, d_instr, {16'hA5A5, exp_pc[15:0]}); else pass_cnt++;
      total_cnt++; if (d_valid !== 1'b1) $display("FAIL zw_dvalid[%0d] got %b want 1", i, d_valid); else pass_cnt++;
`ifdef F_EXC_EN
      total_cnt++; if (d_exc !== 5'd0) $display("FAIL zw_exc[%0d] got %0d want 0", i, d_exc); else pass_cnt++;
`endif
      exp_pc = exp_pc + 32'd4;
    end
    total_cnt++; if (f_pc !== 32'h300C) $display("FAIL zw_fpc got %h want %h", f_pc, 32'h300C); else pass_cnt++;
  endtask

  task automatic test_latency();
    auto_ack = 1'b0; man_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (bus.im_addr !== 32'h3000) $display("FAIL lat_addr[%0d] got %h want %h", i, bus.im_addr, 32'h3000); else pass_cnt++;
      total_cnt++; if (f_wait !== 1'b1) $display("FAIL lat_fwait[%0d] got %b want 1", i, f_wait); else pass_cnt++;
      total_cnt++; if (d_valid !== 1'b0) $display("FAIL lat_dvalid[%0d] got %b want 0", i, d_valid); else pass_cnt++;
      tick();
    end
    man_ack = 1'b1; man_rdata = 32'hDEAD0001;
    #1;
    total_cnt++; if (bus.im_addr !== 32'h3000) $display("FAIL lat_addr_ack got %h want %h", bus.im_addr, 32'h3000); else pass_cnt++;
    total_cnt++; if (f_wait !== 1'b0) $display("FAIL lat_fwait_ack got %b want 0", f_wait); else pass_cnt++;
    tick();
    man_ack = 1'b0;
    #1;
    total_cnt++; if (d_instr !== 32'hDEAD0001) $display("FAIL lat_dinstr got %h want %h", d_instr, 32'hDEAD0001); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h3000) $display("FAIL lat_dpc got %h want %h", d_pc, 32'h3000); else pass_cnt++;
    total_cnt++; if (f_pc !== 32'h3004) $display("FAIL lat_fpc got %h want %h", f_pc, 32'h3004); else pass_cnt++;
    man_rdata = 32'h1111_2222;
    tick();
    total_cnt++; if (d_instr !== 32'hDEAD0001) $display("FAIL lat_dinstr_hold got %h want %h", d_instr, 32'hDEAD0001); else pass_cnt++;
    total_cnt++; if (f_pc !== 32'h3004) $display("FAIL lat_fpc_hold got %h want %h", f_pc, 32'h3004); else pass_cnt++;
  endtask

  task automatic test_stall_hold();
    stall = 1'b1; man_ack = 1'b1; man_rdata = 32'hBEEF0002;
    tick();
    man_ack = 1'b0;
    #1;
    total_cnt++; if (bus.im_req !== 1'b0) $display("FAIL hold_imreq got %b want 0", bus.im_req); else pass_cnt++;
    total_cnt++; if (f_wait !== 1'b0) $display("FAIL hold_fwait got %b want 0", f_wait); else pass_cnt++;
    total_cnt++; if (f_pc !== 32'h3004) $display("FAIL hold_fpc got %h want %h", f_pc, 32'h3004); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h3000) $display("FAIL hold_dpc got %h want %h", d_pc, 32'h3000); else pass_cnt++;
    man_ack = 1'b1; man_rdata = 32'hBAD0_0BAD;
    tick();
    man_ack = 1'b0;
    #1;
    total_cnt++; if (bus.im_req !== 1'b0) $display("FAIL hold_imreq2 got %b want 0", bus.im_req); else pass_cnt++;
    total_cnt++; if (d_instr !== 32'hDEAD0001) $display("FAIL hold_dinstr got %h want %h", d_instr, 32'hDEAD0001); else pass_cnt++;
    tick();
    stall = 1'b0;
    tick();
    total_cnt++; if (d_instr !== 32'hBEEF0002) $display("FAIL hold_release_instr got %h want %h", d_instr, 32'hBEEF0002); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h3004) $display("FAIL hold_release_dpc got %h want %h", d_pc, 32'h3004); else pass_cnt++;
    total_cnt++; if (f_pc !== 32'h3008) $display("FAIL hold_release_fpc got %h want %h", f_pc, 32'h3008); else pass_cnt++;
    total_cnt++; if (bus.im_req !== 1'b1) $display("FAIL hold_release_req got %b want 1", bus.im_req); else pass_cnt++;
    tick();
    total_cnt++; if (f_pc !== 32'h3008) $display("FAIL hold_once_fpc got %h want %h", f_pc, 32'h3008); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h3004) $display("FAIL hold_once_dpc got %h want %h", d_pc, 32'h3004); else pass_cnt++;
  endtask

  task automatic test_branch();
    auto_ack = 1'b1; npc_override = 1'b0;
    do_reset();
    tick();
    total_cnt++; if (f_pc !== 32'h3004) $display("FAIL br_fpc0 got %h want %h", f_pc, 32'h3004); else pass_cnt++;
    npc_override = 1'b1; man_npc = 32'h3100;
    tick();
    npc_override = 1'b0;
    #1;
    total_cnt++; if (d_pc !== 32'h3004) $display("FAIL br_slot_dpc got %h want %h", d_pc, 32'h3004); else pass_cnt++;
    total_cnt++; if (f_pc !== 32'h3100) $display("FAIL br_target_fpc got %h want %h", f_pc, 32'h3100); else pass_cnt++;
    tick();
    total_cnt++; if (d_pc !== 32'h3100) $display("FAIL br_target_dpc got %h want %h", d_pc, 32'h3100); else pass_cnt++;
    total_cnt++; if (d_instr !== 32'hA5A53100) $display("FAIL br_target_instr got %h want %h", d_instr, 32'hA5A53100); else pass_cnt++;
  endtask

  task automatic test_reset_pending();
    auto_ack = 1'b0; man_ack = 1'b0;
    do_reset();
    npc_override = 1'b1; man_npc = 32'h3040;
    man_ack = 1'b1; man_rdata = 32'h7777_0000;
    tick();
    man_ack = 1'b0; npc_override = 1'b0;
    tick();
    total_cnt++; if (f_pc !== 32'h3040) $display("FAIL rp_fpc got %h want %h", f_pc, 32'h3040); else pass_cnt++;
    total_cnt++; if (bus.im_req !== 1'b1) $display("FAIL rp_req_pending got %b want 1", bus.im_req); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (bus.im_req !== 1'b0) $display("FAIL rp_req_in_reset got %b want 0", bus.im_req); else pass_cnt++;
    tick();
    total_cnt++; if (f_pc !== 32'h3000) $display("FAIL rp_fpc_reset got %h want %h", f_pc, 32'h3000); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b0) $display("FAIL rp_dvalid got %b want 0", d_valid); else pass_cnt++;
    total_cnt++; if (d_instr !== 32'h0) $display("FAIL rp_dinstr got %h want 0", d_instr); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (bus.im_req !== 1'b1) $display("FAIL rp_req_after got %b want 1", bus.im_req); else pass_cnt++;
    total_cnt++; if (bus.im_addr !== 32'h3000) $display("FAIL rp_addr_after got %h want %h", bus.im_addr, 32'h3000); else pass_cnt++;
  endtask

`ifdef F_EXC_EN
  task automatic test_fault();
    auto_ack = 1'b0; man_ack = 1'b0;
    do_reset();
    npc_override = 1'b1; man_npc = 32'h3002;
    man_ack = 1'b1; man_rdata = 32'h1234_5678;
    tick();
    man_ack = 1'b0; man_npc = 32'h3008;
    #1;
    total_cnt++; if (f_pc !== 32'h3002) $display("FAIL flt_fpc got %h want %h", f_pc, 32'h3002); else pass_cnt++;
    total_cnt++; if (bus.im_req !== 1'b0) $display("FAIL flt_req got %b want 0", bus.im_req); else pass_cnt++;
    total_cnt++; if (f_wait !== 1'b0) $display("FAIL flt_fwait got %b want 0", f_wait); else pass_cnt++;
    tick();
    npc_override = 1'b0;
    #1;
    total_cnt++; if (d_exc !== 5'd4) $display("FAIL flt_exc got %0d want 4", d_exc); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h3002) $display("FAIL flt_dpc got %h want %h", d_pc, 32'h3002); else pass_cnt++;
    total_cnt++; if (d_instr !== 32'h0) $display("FAIL flt_dinstr got %h want 0", d_instr); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b1) $display("FAIL flt_dvalid got %b want 1", d_valid); else pass_cnt++;
    total_cnt++; if (f_pc !== 32'h3008) $display("FAIL flt_next_fpc got %h want %h", f_pc, 32'h3008); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_branch();
    test_reset_pending();
`ifdef F_EXC_EN
    test_fault();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
